// File: rtl/quad_enc_pkg.sv
// Shared types and helpers for the quadrature encoder decoder.
// Defines the A/B pair type, the Gray-code state constants, the
// per-edge step classification, the decoder FSM states and the
// transition decoder function.
package quad_enc_pkg;

    typedef logic [1:0] ab_t;

    // Encoder levels as {B, A}
    localparam ab_t AB_00 = 2'b00;
    localparam ab_t AB_01 = 2'b01;
    localparam ab_t AB_11 = 2'b11;
    localparam ab_t AB_10 = 2'b10;

    typedef enum logic [1:0] {
        QS_NONE = 2'd0,
        QS_FWD  = 2'd1,
        QS_REV  = 2'd2,
        QS_ERR  = 2'd3
    } qstep_t;

    typedef enum logic {
        QST_INIT  = 1'b0,
        QST_TRACK = 1'b1
    } qstate_t;

    // Successor of a level in the forward sequence 00->01->11->10->00.
    function automatic ab_t qnext_fwd(input ab_t cur);
        ab_t nxt;
        case (cur)
            AB_00:   nxt = AB_01;
            AB_01:   nxt = AB_11;
            AB_11:   nxt = AB_10;
            AB_10:   nxt = AB_00;
            default: nxt = AB_00;
        endcase
        return nxt;
    endfunction

    // Classify one transition between two accepted A/B levels.
    // A single-bit change is a step in one direction; a two-bit
    // change cannot be attributed to a direction and is illegal.
    function automatic qstep_t qdecode(input ab_t prev, input ab_t cur);
        qstep_t res;
        if (cur == prev) begin
            res = QS_NONE;
        end else if (cur == qnext_fwd(prev)) begin
            res = QS_FWD;
        end else if (prev == qnext_fwd(cur)) begin
            res = QS_REV;
        end else begin
            res = QS_ERR;
        end
        return res;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Single-channel glitch filter for one encoder line.
// A new level is accepted only after the raw input has differed from
// the accepted level on FILT_LEN consecutive clock edges; any edge on
// which the raw input matches the accepted level restarts the count.
// 'load' forces the accepted level to the raw input without filtering,
// used to seed the filter on the first edge after reset.
module quad_glitch_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic raw,
    output logic acc
);

    // Count value on which the FILT_LEN-th differing edge is seen
    localparam logic [3:0] LAST_CNT = 4'(FILT_LEN - 1);

    logic [3:0] cnt_r;
    logic       acc_r;

    // Run-length counter and accepted level update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= 4'd0;
            acc_r <= 1'b0;
        end else if (load) begin
            cnt_r <= 4'd0;
            acc_r <= raw;
        end else if (raw == acc_r) begin
            cnt_r <= 4'd0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= 4'd0;
            acc_r <= raw;
        end else begin
            cnt_r <= cnt_r + 4'd1;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: glitch-filters the A/B inputs, follows the
// 4-state Gray sequence and keeps a wrapping position count with
// direction, per-step strobe and sticky illegal-transition flag.
// Optional index-pulse capture is built when QUAD_DECODER_INDEX_Z_EN
// is defined; without it the idx_* ports and logic are absent.
module quad_decoder
    import quad_enc_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inQ,
    input  logic             clr,
    output logic [CNT_W-1:0] pos_cnt,
    output logic             dir,
    output logic             step,
    output logic             err
`ifdef QUAD_DECODER_INDEX_Z_EN
    ,
    input  logic             idx_z,
    output logic [CNT_W-1:0] idx_pos,
    output logic             idx_pulse
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    qstate_t state_r;
    ab_t     prev_r;
    ab_t     acc_s;
    logic    load_s;
    qstep_t  qs_s;
    logic    idx_take_s;
    logic    fwd_s;
    logic    rev_s;

`ifdef QUAD_DECODER_INDEX_Z_EN
    logic    idx_z_r;
`endif

    // The first edge after reset seeds the filters straight from inQ
    assign load_s = (state_r == QST_INIT);

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .raw  (inQ[0]),
        .acc  (acc_s[0])
    );

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .raw  (inQ[1]),
        .acc  (acc_s[1])
    );

    // Classify the accepted transition and arbitrate clear > index > step.
    always_comb begin
        qs_s       = QS_NONE;
        idx_take_s = 1'b0;
        fwd_s      = 1'b0;
        rev_s      = 1'b0;
        if (state_r == QST_TRACK) begin
            qs_s = qdecode(prev_r, acc_s);
`ifdef QUAD_DECODER_INDEX_Z_EN
            idx_take_s = idx_z & ~idx_z_r & (acc_s == AB_00) & ~clr;
`else
            idx_take_s = 1'b0;
`endif
        end else begin
            qs_s       = QS_NONE;
            idx_take_s = 1'b0;
        end
        // An index event swallows a same-cycle step entirely
        fwd_s = (qs_s == QS_FWD) & ~idx_take_s;
        rev_s = (qs_s == QS_REV) & ~idx_take_s;
    end

    // Decoder FSM with registered position, direction, strobe and error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= QST_INIT;
            prev_r  <= AB_00;
            pos_cnt <= CNT_ZERO;
            dir     <= 1'b0;
            step    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                QST_INIT: begin
                    // Filters are loaded this edge; match prev so no step follows
                    prev_r  <= inQ;
                    state_r <= QST_TRACK;
                end
                QST_TRACK: begin
                    prev_r  <= acc_s;
                    state_r <= QST_TRACK;
                end
                default: begin
                    prev_r  <= AB_00;
                    state_r <= QST_INIT;
                end
            endcase

            step <= fwd_s | rev_s;
            if (fwd_s | rev_s) begin
                dir <= fwd_s;
            end

            if (clr | idx_take_s) begin
                pos_cnt <= CNT_ZERO;
            end else if (fwd_s) begin
                pos_cnt <= pos_cnt + CNT_ONE;
            end else if (rev_s) begin
                pos_cnt <= pos_cnt - CNT_ONE;
            end

            if (clr) begin
                err <= 1'b0;
            end else if (qs_s == QS_ERR) begin
                err <= 1'b1;
            end
        end
    end

`ifdef QUAD_DECODER_INDEX_Z_EN
    // Index edge detect and capture of the pre-clear position.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_z_r   <= 1'b0;
            idx_pos   <= CNT_ZERO;
            idx_pulse <= 1'b0;
        end else begin
            idx_z_r   <= idx_z;
            idx_pulse <= idx_take_s;
            if (idx_take_s) begin
                idx_pos <= pos_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed sequences, a table of
// Gray transitions with hand-computed results, and randomized stimulus
// compared every cycle against a history-window reference model.
// Define QUAD_DECODER_INDEX_Z_EN to also exercise the index feature.
module tb_quad_decoder;

    localparam int CNT_W    = 16;
    localparam int FILT_LEN = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       inQ = 2'b00;
    logic             clr = 1'b0;
    logic             idx_z = 1'b0;
    logic [CNT_W-1:0] pos_cnt;
    logic             dir;
    logic             step;
    logic             err;
    logic [CNT_W-1:0] idx_pos;
    logic             idx_pulse;

    quad_decoder #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .inQ       (inQ),
        .clr       (clr),
        .pos_cnt   (pos_cnt),
        .dir       (dir),
        .step      (step),
        .err       (err)
`ifdef QUAD_DECODER_INDEX_Z_EN
        ,
        .idx_z     (idx_z),
        .idx_pos   (idx_pos),
        .idx_pulse (idx_pulse)
`endif
    );

`ifndef QUAD_DECODER_INDEX_Z_EN
    assign idx_pos   = {CNT_W{1'b0}};
    assign idx_pulse = 1'b0;
`endif

    always #5 clk = ~clk;

    int vec_n     = 0;
    int err_n     = 0;
    int step_seen = 0;

    // Reference model state
    logic [CNT_W-1:0] m_pos;
    logic             m_dir, m_step, m_err;
    logic [1:0]       m_acc, m_prev;
    bit               m_init;
    logic [1:0]       hist[$];
    logic             m_idx_prev;
    logic [CNT_W-1:0] m_idx_pos;
    logic             m_idx_pulse;

    logic [1:0] gseq [4];

    typedef struct {
        logic [1:0]       q;
        int               hold;
        logic [CNT_W-1:0] exp_pos;
        logic             exp_dir;
        logic             exp_err;
        int               exp_steps;
    } vec_t;

    vec_t tbl [10];

    // Position of a level on the Gray wheel
    function automatic int gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Advance the model by one rising edge with the sampled inputs
    task automatic model_edge(input logic r, input logic [1:0] q, input logic c, input logic iz);
        int  d;
        bit  fwd, rev, idxev, all;
        if (!r) begin
            m_pos = '0; m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0;
            m_acc = 2'b00; m_prev = 2'b00; m_init = 1'b1; hist.delete();
            m_idx_prev = 1'b0; m_idx_pos = '0; m_idx_pulse = 1'b0;
        end else begin
            d     = m_init ? 0 : (gray_idx(m_acc) - gray_idx(m_prev) + 4) % 4;
            fwd   = (d == 1);
            rev   = (d == 3);
`ifdef QUAD_DECODER_INDEX_Z_EN
            idxev = !m_init && iz && !m_idx_prev && (m_acc == 2'b00) && !c;
`else
            idxev = 1'b0;
`endif
            if (!idxev && (fwd || rev)) begin
                m_step = 1'b1;
                m_dir  = fwd;
            end else begin
                m_step = 1'b0;
            end
            m_idx_pulse = idxev;
            if (idxev) m_idx_pos = m_pos;
            if (c || idxev)       m_pos = '0;
            else if (m_step && fwd) m_pos = m_pos + 1'b1;
            else if (m_step && rev) m_pos = m_pos - 1'b1;
            if (c)           m_err = 1'b0;
            else if (d == 2) m_err = 1'b1;
            if (m_init) begin
                m_acc = q; m_prev = q; hist.delete(); hist.push_back(q); m_init = 1'b0;
            end else begin
                m_prev = m_acc;
                hist.push_back(q);
                if (hist.size() > FILT_LEN) void'(hist.pop_front());
                for (int ch = 0; ch < 2; ch++) begin
                    all = (hist.size() == FILT_LEN);
                    foreach (hist[i]) if (hist[i][ch] == m_acc[ch]) all = 1'b0;
                    if (all) m_acc[ch] = ~m_acc[ch];
                end
            end
            m_idx_prev = iz;
        end
    endtask

    task automatic check_model();
        bit ok;
        vec_n++;
        ok = (pos_cnt === m_pos) && (dir === m_dir) && (step === m_step) && (err === m_err);
`ifdef QUAD_DECODER_INDEX_Z_EN
        ok = ok && (idx_pos === m_idx_pos) && (idx_pulse === m_idx_pulse);
`endif
        if (!ok) begin
            err_n++;
            $display("FAIL model t=%0t pos=%h exp %h dir=%b exp %b step=%b exp %b err=%b exp %b idx_pos=%h exp %h idx_pulse=%b exp %b",
                     $time, pos_cnt, m_pos, dir, m_dir, step, m_step, err, m_err,
                     idx_pos, m_idx_pos, idx_pulse, m_idx_pulse);
        end
        if (step === 1'b1) step_seen++;
    endtask

    task automatic expect_val(input string name, input int act, input int exp);
        vec_n++;
        if (act != exp) begin
            err_n++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive after falling edge, model at rising edge, check 1ns later
    task automatic cyc(input logic r, input logic [1:0] q, input logic c, input logic iz);
        @(negedge clk);
        rst = r; inQ = q; clr = c; idx_z = iz;
        @(posedge clk);
        model_edge(r, q, c, iz);
        #1;
        check_model();
    endtask

    task automatic hold(input logic [1:0] q, input int n);
        repeat (n) cyc(1'b1, q, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic [1:0] q);
        repeat (3) cyc(1'b0, q, 1'b0, 1'b0);
        cyc(1'b1, q, 1'b0, 1'b0);
    endtask

    initial begin
        int s0;
        logic [1:0] cur_q;
        logic       iz;
        gseq[0] = 2'b00; gseq[1] = 2'b01; gseq[2] = 2'b11; gseq[3] = 2'b10;

        // Table: from reset at 00, each level held 5 clocks
        tbl[0] = '{2'b01, 5, 16'd1, 1'b1, 1'b0, 1};
        tbl[1] = '{2'b11, 5, 16'd2, 1'b1, 1'b0, 1};
        tbl[2] = '{2'b10, 5, 16'd3, 1'b1, 1'b0, 1};
        tbl[3] = '{2'b00, 5, 16'd4, 1'b1, 1'b0, 1};
        tbl[4] = '{2'b10, 5, 16'd3, 1'b0, 1'b0, 1};
        tbl[5] = '{2'b11, 5, 16'd2, 1'b0, 1'b0, 1};
        tbl[6] = '{2'b01, 5, 16'd1, 1'b0, 1'b0, 1};
        tbl[7] = '{2'b01, 5, 16'd1, 1'b0, 1'b0, 0};
        tbl[8] = '{2'b10, 5, 16'd1, 1'b0, 1'b1, 0};
        tbl[9] = '{2'b00, 5, 16'd2, 1'b1, 1'b1, 1};

        // 1: reset held with inQ=11, release, no step
        repeat (3) cyc(1'b0, 2'b11, 1'b0, 1'b0);
        expect_val("reset_pos", int'(pos_cnt), 0);
        expect_val("reset_err", int'(err), 0);
        s0 = step_seen;
        hold(2'b11, 6);
        expect_val("init_steps", step_seen - s0, 0);
        expect_val("init_pos", int'(pos_cnt), 0);
        expect_val("init_err", int'(err), 0);

        // 2: four forward cycles then four reverse steps
        do_reset(2'b00);
        s0 = step_seen;
        for (int i = 1; i <= 16; i++) hold(gseq[i % 4], 5);
        expect_val("fwd16_pos", int'(pos_cnt), 16);
        expect_val("fwd16_dir", int'(dir), 1);
        expect_val("fwd16_steps", step_seen - s0, 16);
        for (int i = 1; i <= 4; i++) hold(gseq[(4 - i) % 4], 5);
        expect_val("rev4_pos", int'(pos_cnt), 12);
        expect_val("rev4_dir", int'(dir), 0);

        // 3: glitch shorter than the filter, then exactly filter length
        s0 = step_seen;
        hold(2'b01, 2);
        hold(2'b00, 6);
        expect_val("glitch2_steps", step_seen - s0, 0);
        expect_val("glitch2_pos", int'(pos_cnt), 12);
        s0 = step_seen;
        hold(2'b01, 3);
        hold(2'b00, 1);
        expect_val("glitch3_steps", step_seen - s0, 1);
        expect_val("glitch3_pos", int'(pos_cnt), 13);
        hold(2'b00, 5);
        expect_val("glitch3_back_pos", int'(pos_cnt), 12);

        // 4: double-bit change sets err, clr clears err and position
        hold(2'b11, 6);
        expect_val("dbl_err", int'(err), 1);
        expect_val("dbl_pos", int'(pos_cnt), 12);
        cyc(1'b1, 2'b11, 1'b1, 1'b0);
        hold(2'b11, 2);
        expect_val("clr_err", int'(err), 0);
        expect_val("clr_pos", int'(pos_cnt), 0);

        // 5: wrap below zero and back
        hold(2'b01, 5);
        expect_val("wrap_down", int'(pos_cnt), 16'hFFFF);
        hold(2'b11, 5);
        expect_val("wrap_up", int'(pos_cnt), 0);

`ifdef QUAD_DECODER_INDEX_Z_EN
        // 6: index at AB=00 captures and clears; at AB=01 ignored
        hold(2'b10, 5);
        cyc(1'b1, 2'b10, 1'b1, 1'b0);
        hold(2'b00, 5);
        for (int i = 1; i <= 36; i++) hold(gseq[i % 4], 5);
        expect_val("idx_pre_pos", int'(pos_cnt), 37);
        cyc(1'b1, 2'b00, 1'b0, 1'b1);
        expect_val("idx_pulse_hi", int'(idx_pulse), 1);
        expect_val("idx_pos_cap", int'(idx_pos), 37);
        expect_val("idx_pos_clr", int'(pos_cnt), 0);
        cyc(1'b1, 2'b00, 1'b0, 1'b1);
        expect_val("idx_pulse_lo", int'(idx_pulse), 0);
        cyc(1'b1, 2'b00, 1'b0, 1'b0);
        hold(2'b01, 5);
        cyc(1'b1, 2'b01, 1'b0, 1'b1);
        expect_val("idx_ign_pulse", int'(idx_pulse), 0);
        expect_val("idx_ign_pos", int'(pos_cnt), 1);
        expect_val("idx_ign_cap", int'(idx_pos), 37);
        cyc(1'b1, 2'b01, 1'b0, 1'b0);
`endif

        // Randomized phases checked against the model every cycle
        do_reset(2'b00);
        cur_q = 2'b00;
        iz    = 1'b0;
        for (int n = 0; n < 400; n++) begin
            int k, len;
            if ($urandom_range(0, 99) < 3) begin
                cur_q = 2'($urandom_range(0, 3));
                repeat (2) cyc(1'b0, cur_q, 1'b0, 1'b0);
            end else begin
                k = $urandom_range(0, 9);
                if (k < 4)      cur_q = gseq[(gray_idx(cur_q) + 1) % 4];
                else if (k < 8) cur_q = gseq[(gray_idx(cur_q) + 3) % 4];
                else if (k == 9) cur_q = ~cur_q;
                len = $urandom_range(1, 6);
                repeat (len) begin
                    if ($urandom_range(0, 7) == 0) iz = ~iz;
                    cyc(1'b1, cur_q, ($urandom_range(0, 49) == 0), iz);
                end
            end
        end

        // Table-driven Gray transitions with hand-computed results
        do_reset(2'b00);
        foreach (tbl[i]) begin
            s0 = step_seen;
            hold(tbl[i].q, tbl[i].hold);
            expect_val($sformatf("tbl%0d_pos", i), int'(pos_cnt), int'(tbl[i].exp_pos));
            expect_val($sformatf("tbl%0d_dir", i), int'(dir), int'(tbl[i].exp_dir));
            expect_val($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].exp_err));
            expect_val($sformatf("tbl%0d_steps", i), step_seen - s0, tbl[i].exp_steps);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
